// File: rtl/collect_2x1_seq.sv
// rtl/collect_2x1_seq.sv - sequential 2-to-1 collection switch with one-entry hold buffer
//
// Merges two input lanes onto one output lane under a per-cycle command.
// When both lanes are taken in one cycle, the low word goes straight to the
// output register and the high word waits in the hold entry. This serialises
// the pair low-first and never drops a word.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   i_valid     per-lane valid, bit 0 = low lane, bit 1 = high lane
//   i_data_bus  {data_high, data_low}
//   o_ready     per-lane accept, combinational from state/i_ready/i_en/i_cmd
//   o_valid     output word valid
//   o_data_bus  output word, zero when o_valid = 0
//   o_src       lane the output word came from (0 low, 1 high)
//   i_ready     upstream accepts the output word this cycle
//   i_en        gates acceptance only; buffered words still drain
//   i_cmd       00 none, 01 low only, 10 high only, 11 both
module collect_2x1_seq #(
    parameter int DATA_WIDTH     = 32,
    parameter int COMMMAND_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                i_valid,
    input  logic [2*DATA_WIDTH-1:0]   i_data_bus,
    output logic [1:0]                o_ready,
    output logic                      o_valid,
    output logic [DATA_WIDTH-1:0]     o_data_bus,
    output logic                      o_src,
    input  logic                      i_ready,
    input  logic                      i_en,
    input  logic [COMMMAND_WIDTH-1:0] i_cmd
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic                  valid_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  src_nxt;
    logic [DATA_WIDTH-1:0] hold_data, hold_nxt;

    logic                  pop;
    logic                  space;
    logic [1:0]            acc;
    logic [DATA_WIDTH-1:0] data_low, data_high;

    assign data_low  = i_data_bus[DATA_WIDTH-1:0];
    assign data_high = i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH];

    assign pop   = o_valid & i_ready;
    assign space = (state == S_EMPTY) | ((state == S_ONE) & i_ready);

    // rst is folded in so no lane is offered acceptance while reset is held.
    assign o_ready = i_cmd[1:0] & {2{i_en & space & rst}};
    assign acc     = i_valid & o_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_EMPTY;
            o_valid    <= 1'b0;
            o_data_bus <= '0;
            o_src      <= 1'b0;
            hold_data  <= '0;
        end else begin
            state      <= state_nxt;
            o_valid    <= valid_nxt;
            o_data_bus <= data_nxt;
            o_src      <= src_nxt;
            hold_data  <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        valid_nxt = o_valid;
        data_nxt  = o_data_bus;
        src_nxt   = o_src;
        hold_nxt  = hold_data;

        case (state)
            S_EMPTY, S_ONE: begin
                // Without space (S_ONE and no pop) nothing is accepted and
                // the output register holds.
                if (space) begin
                    case (acc)
                        2'b11: begin
                            valid_nxt = 1'b1;
                            data_nxt  = data_low;
                            src_nxt   = 1'b0;
                            hold_nxt  = data_high;
                            state_nxt = S_TWO;
                        end
                        2'b01: begin
                            valid_nxt = 1'b1;
                            data_nxt  = data_low;
                            src_nxt   = 1'b0;
                            state_nxt = S_ONE;
                        end
                        2'b10: begin
                            valid_nxt = 1'b1;
                            data_nxt  = data_high;
                            src_nxt   = 1'b1;
                            state_nxt = S_ONE;
                        end
                        default: begin
                            // Popped with nothing to replace it: go idle.
                            valid_nxt = 1'b0;
                            data_nxt  = '0;
                            src_nxt   = 1'b0;
                            state_nxt = S_EMPTY;
                        end
                    endcase
                end
            end
            S_TWO: begin
                if (pop) begin
                    valid_nxt = 1'b1;
                    data_nxt  = hold_data;
                    src_nxt   = 1'b1;
                    hold_nxt  = '0;
                    state_nxt = S_ONE;
                end
            end
            default: begin
                valid_nxt = 1'b0;
                data_nxt  = '0;
                src_nxt   = 1'b0;
                hold_nxt  = '0;
                state_nxt = S_EMPTY;
            end
        endcase
    end

endmodule

// File: tb/tb_collect_2x1_seq.sv
// tb/tb_collect_2x1_seq.sv - scoreboard testbench for collect_2x1_seq
module tb_collect_2x1_seq;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    i_valid = '0;
    logic [2*DW-1:0] i_data_bus = '0;
    logic [1:0]    o_ready;
    logic          o_valid;
    logic [DW-1:0] o_data_bus;
    logic          o_src;
    logic          i_ready = 1'b0;
    logic          i_en = 1'b0;
    logic [1:0]    i_cmd = '0;

    int checks = 0;
    int errors = 0;
    int occ = 0;
    logic [DW:0] sb_q[$];

    always #5 clk = ~clk;

    collect_2x1_seq #(.DATA_WIDTH(DW), .COMMMAND_WIDTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus),
        .o_src      (o_src),
        .i_ready    (i_ready),
        .i_en       (i_en),
        .i_cmd      (i_cmd)
    );

    // Monitor: every popped word must be the oldest outstanding expected word.
    always @(negedge clk) begin
        if (rst && o_valid && i_ready) begin
            logic [DW:0] exp_w;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected got data=%h src=%0d, required no output", o_data_bus, o_src);
            end else begin
                exp_w = sb_q.pop_front();
                if ({o_src, o_data_bus} !== exp_w) begin
                    errors++;
                    $display("FAIL pop_word got src=%0d data=%h, required src=%0d data=%h",
                             o_src, o_data_bus, exp_w[DW], exp_w[DW-1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [DW+3:0] got, input logic [DW+3:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h, required %h", name, got, req);
        end
    endtask

    task automatic check_out(input logic v, input logic [DW-1:0] d, input logic s);
        check("out_state", {2'b0, v, s, o_data_bus}, {2'b0, o_valid, o_src, o_data_bus} ^ {2'b0, o_valid ^ v, o_src ^ s, o_data_bus ^ d});
    endtask

    // One clock of stimulus. Called #1 after a rising edge; returns #1 after the next one.
    task automatic cycle(input logic [1:0] v, input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                         input logic [1:0] cmd, input logic en, input logic rdy);
        logic [1:0] exp_rdy;
        logic [1:0] acc;
        int         pop;
        i_valid    = v;
        i_data_bus = {hi, lo};
        i_cmd      = cmd;
        i_en       = en;
        i_ready    = rdy;
        @(negedge clk);
        exp_rdy = cmd & {2{en && (occ == 0 || (occ == 1 && rdy))}};
        check("o_ready", {{DW{1'b0}}, 2'b0, o_ready}, {{DW{1'b0}}, 2'b0, exp_rdy});
        check("o_valid", {{DW{1'b0}}, 3'b0, o_valid}, {{DW{1'b0}}, 3'b0, occ != 0});
        if (occ == 0)
            check("idle_zero", {3'b0, o_src, o_data_bus}, '0);
        pop = (occ != 0 && rdy) ? 1 : 0;
        acc = v & exp_rdy;
        if (acc[0]) sb_q.push_back({1'b0, lo});
        if (acc[1]) sb_q.push_back({1'b1, hi});
        occ = occ - pop + int'(acc[0]) + int'(acc[1]);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_out", {1'b0, o_ready, o_valid, o_src, o_data_bus}, '0);
        @(negedge clk);
        sb_q.delete();
        occ = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        // Reset state
        i_cmd = 2'b11;
        i_en  = 1'b1;
        i_valid = 2'b11;
        @(posedge clk);
        #1;
        do_reset();

        // First acceptance right after reset release
        cycle(2'b01, 32'hA5, 32'h0, 2'b01, 1'b1, 1'b0);
        check_out(1'b1, 32'hA5, 1'b0);
        cycle(2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b1);
        check_out(1'b0, 32'h0, 1'b0);

        // Single lane streaming, high lane
        for (int k = 1; k <= 4; k++) begin
            cycle(2'b11, 32'hF0 + k, k, 2'b10, 1'b1, 1'b1);
            check_out(1'b1, k, 1'b1);
        end
        cycle(2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b1);
        check_out(1'b0, 32'h0, 1'b0);

        // Serialise pairs
        cycle(2'b11, 32'h11, 32'h22, 2'b11, 1'b1, 1'b1);
        check_out(1'b1, 32'h11, 1'b0);
        cycle(2'b11, 32'h33, 32'h44, 2'b11, 1'b1, 1'b1);
        check_out(1'b1, 32'h22, 1'b1);
        cycle(2'b11, 32'h33, 32'h44, 2'b11, 1'b1, 1'b1);
        check_out(1'b1, 32'h33, 1'b0);
        cycle(2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b1);
        check_out(1'b1, 32'h44, 1'b1);
        cycle(2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b1);
        check_out(1'b0, 32'h0, 1'b0);

        // Backpressure in S_TWO
        cycle(2'b11, 32'hAA, 32'hBB, 2'b11, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check_out(1'b1, 32'hAA, 1'b0);
            cycle(2'b11, 32'h1, 32'h2, 2'b11, 1'b1, 1'b0);
        end
        check_out(1'b1, 32'hAA, 1'b0);
        cycle(2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b1);
        check_out(1'b1, 32'hBB, 1'b1);
        cycle(2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b1);
        check_out(1'b0, 32'h0, 1'b0);

        // Enable off / no command
        cycle(2'b01, 32'h5C, 32'h0, 2'b01, 1'b1, 1'b0);
        check_out(1'b1, 32'h5C, 1'b0);
        cycle(2'b11, 32'h1, 32'h2, 2'b11, 1'b0, 1'b1);
        check_out(1'b0, 32'h0, 1'b0);
        cycle(2'b11, 32'h1, 32'h2, 2'b00, 1'b1, 1'b1);
        check_out(1'b0, 32'h0, 1'b0);

        // Reset mid-stream while holding two words
        cycle(2'b11, 32'hC1, 32'hC2, 2'b11, 1'b1, 1'b0);
        check_out(1'b1, 32'hC1, 1'b0);
        i_cmd = 2'b11;
        i_en  = 1'b1;
        i_ready = 1'b1;
        do_reset();
        cycle(2'b01, 32'hA5, 32'h0, 2'b01, 1'b1, 1'b0);
        check_out(1'b1, 32'hA5, 1'b0);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            cycle(2'($urandom), $urandom, $urandom, 2'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0));
        end

        // Drain
        for (int k = 0; k < 4; k++)
            cycle(2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b1);
        check("drained", {DW + 4{1'b0}} | (DW + 4)'(sb_q.size()), '0);
        check_out(1'b0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
